// File: rtl/nettlp_cmd_arb_pkg.sv
// Shared types for the nettlp_cmd requester arbiter: command word, requester ID, response FSM.
package nettlp_cmd_arb_pkg;

    localparam int unsigned NETTLP_CMD_NREQ_MAX = 8;

    typedef logic [2:0] NETTLP_REQ_ID_T;

    typedef struct packed {
        logic [3:0]  opcode;
        logic [7:0]  tag;
        logic [31:0] addr;
        logic [31:0] data;
    } FIFO_NETTLP_CMD_T;

    localparam int unsigned CMD_W = $bits(FIFO_NETTLP_CMD_T);

    typedef enum logic [0:0] {RspIdle, RspHold} rsp_state_e;

    function automatic logic [NETTLP_CMD_NREQ_MAX-1:0] id_onehot(input NETTLP_REQ_ID_T id);
        return NETTLP_CMD_NREQ_MAX'(1) << id;
    endfunction

endpackage

// File: rtl/nettlp_cmd_arb_if.sv
// Requester-side bundle: per-requester command handshake plus the shared response bus.
interface nettlp_cmd_arb_if #(
    parameter int unsigned NREQ = 2
);
    import nettlp_cmd_arb_pkg::*;

    logic             [NREQ-1:0] req_valid;
    logic             [NREQ-1:0] req_ready;
    FIFO_NETTLP_CMD_T [NREQ-1:0] req_cmd;
    logic             [NREQ-1:0] rsp_valid;
    logic             [NREQ-1:0] rsp_ready;
    FIFO_NETTLP_CMD_T            rsp_cmd;

    modport master (
        output req_valid, req_cmd, rsp_ready,
        input  req_ready, rsp_valid, rsp_cmd
    );

    modport slave (
        input  req_valid, req_cmd, rsp_ready,
        output req_ready, rsp_valid, rsp_cmd
    );

endinterface

// File: rtl/nettlp_cmd_arb_tagq.sv
// In-order queue of requester IDs for commands in flight; head names the owner of the next response.
module nettlp_cmd_arb_tagq
    import nettlp_cmd_arb_pkg::*;
#(
    parameter  int unsigned Depth = 8,
    localparam int unsigned PtrW  = $clog2(Depth)
) (
    input  logic           clk_i,
    input  logic           rst_ni,
    input  logic           push_i,
    input  NETTLP_REQ_ID_T id_i,
    input  logic           pop_i,
    output logic           full_o,
    output logic           empty_o,
    output NETTLP_REQ_ID_T head_o,
    output logic [PtrW:0]  count_o
);

    NETTLP_REQ_ID_T mem_q [Depth];
    logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
    logic [PtrW:0]   count_q;
    logic            do_push, do_pop;

    assign full_o  = (count_q == (PtrW+1)'(Depth));
    assign empty_o = (count_q == '0);
    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;
    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;

    // Depth is a power of two, so the pointers wrap naturally.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= id_i;
                wr_ptr_q        <= wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            unique case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/nettlp_cmd_arb.sv
// Round-robin sharing of one nettlp_cmd engine among NREQ requesters, with in-order response steering.
module nettlp_cmd_arb
    import nettlp_cmd_arb_pkg::*;
#(
    parameter  int unsigned NREQ      = 2,
    parameter  int unsigned MAX_OUTST = 8,
    localparam int unsigned IDW       = $clog2(NREQ),
    localparam int unsigned CNTW      = $clog2(MAX_OUTST) + 1
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    nettlp_cmd_arb_if.slave   req_if,
    output logic              fifo_cmd_i_wr_en_o,
    input  logic              fifo_cmd_i_full_i,
    output FIFO_NETTLP_CMD_T  fifo_cmd_i_din_o,
    output logic              fifo_cmd_o_rd_en_o,
    input  logic              fifo_cmd_o_empty_i,
    input  FIFO_NETTLP_CMD_T  fifo_cmd_o_dout_i,
    output logic [CNTW-1:0]   outstanding_o,
    output logic [15:0]       orphan_cnt_o
);

    logic [IDW-1:0]   rr_ptr_q, winner, rsp_id_q;
    logic             any_valid, issue, tag_pop;
    int unsigned      idx;
    NETTLP_REQ_ID_T   winner_id, tag_head;
    logic             tagq_full, tagq_empty;
    rsp_state_e       state_q;
    logic [NREQ-1:0]  rsp_valid_q;
    FIFO_NETTLP_CMD_T rsp_cmd_q;
    logic [15:0]      orphan_q;

    // First valid requester at or after rr_ptr, wrapping modulo NREQ.
    always_comb begin
        winner    = rr_ptr_q;
        any_valid = 1'b0;
        idx       = 0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            idx = (32'(rr_ptr_q) + k) % NREQ;
            if (!any_valid && req_if.req_valid[IDW'(idx)]) begin
                winner    = IDW'(idx);
                any_valid = 1'b1;
            end
        end
    end

    assign winner_id          = 3'(winner);
    assign issue              = rst_ni & any_valid & ~fifo_cmd_i_full_i & ~tagq_full;
    assign req_if.req_ready   = issue ? NREQ'(id_onehot(winner_id)) : '0;
    assign fifo_cmd_i_wr_en_o = issue;
    assign fifo_cmd_i_din_o   = req_if.req_cmd[winner];

    assign fifo_cmd_o_rd_en_o = rst_ni & (state_q == RspIdle) & ~fifo_cmd_o_empty_i;
    assign tag_pop            = fifo_cmd_o_rd_en_o & ~tagq_empty;

    assign req_if.rsp_valid   = rsp_valid_q;
    assign req_if.rsp_cmd     = rsp_cmd_q;
    assign orphan_cnt_o       = orphan_q;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            rr_ptr_q <= '0;
        end else if (issue) begin
            rr_ptr_q <= (winner == IDW'(NREQ - 1)) ? '0 : winner + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q     <= RspIdle;
            rsp_valid_q <= '0;
            rsp_cmd_q   <= '0;
            rsp_id_q    <= '0;
            orphan_q    <= '0;
        end else begin
            unique case (state_q)
                RspIdle: begin
                    if (tag_pop) begin
                        rsp_cmd_q   <= fifo_cmd_o_dout_i;
                        rsp_id_q    <= tag_head[IDW-1:0];
                        rsp_valid_q <= NREQ'(id_onehot(tag_head));
                        state_q     <= RspHold;
                    end else if (fifo_cmd_o_rd_en_o && orphan_q != 16'hFFFF) begin
                        // Response with no recorded owner: dropped, only counted.
                        orphan_q <= orphan_q + 16'd1;
                    end
                end
                RspHold: begin
                    if (req_if.rsp_ready[rsp_id_q]) begin
                        rsp_valid_q <= '0;
                        state_q     <= RspIdle;
                    end
                end
                default: state_q <= RspIdle;
            endcase
        end
    end

    nettlp_cmd_arb_tagq #(
        .Depth (MAX_OUTST)
    ) u_tagq (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (issue),
        .id_i    (winner_id),
        .pop_i   (tag_pop),
        .full_o  (tagq_full),
        .empty_o (tagq_empty),
        .head_o  (tag_head),
        .count_o (outstanding_o)
    );

endmodule
